scrambler_gen: RTL and testbench
================================

Name: scrambler_gen

Overview:
- Parametrised self-synchronous scrambler/descrambler, polynomial G(x)=1+x^39+x^58 (IEEE 802.3 clause 49), for the PCS datapath.
- Generalises the fixed 64-bit scrambler in four ways: any lane width; compile-time scramble or descramble mode; a registered output stage with valid/ready handshake; and seed load with a self-sync lock indication.
- Sits between the 64b/66b encoder and the gearbox on TX. On RX it sits between the block-sync stage and the decoder.

Parameters:
- DATA_W, 64, beat width in bits, 1 to 256; bit 0 is first on the wire (oldest).
- MODE, 0, 0 = scramble, 1 = descramble.
- SEED_W, 58, state width; fixed at 58, exposed only for port sizing.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seed_load  input  1  one-cycle pulse: state <= seed.
- seed  input  SEED_W  seed value; bit 57 is the most recent bit.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  input beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  scrambled or descrambled beat.
- out_locked  output  1  the beat in the output register is fully self-synchronised.
- locked  output  1  live status: the state holds only line-derived bits.

Behaviour:
- Per-bit equations, i = 0..DATA_W-1, with h[] = history where h[-1] is the most recent state bit:
  - Scramble: s[i] = d[i] ^ h[i-39] ^ h[i-58], where h = scrambled bits.
  - Descramble: d[i] = s[i] ^ h[i-39] ^ h[i-58], where h = received scrambled bits.
  - The equations must be correct for every DATA_W, including DATA_W < 39 and DATA_W > 58. In-beat taps resolve to bits already computed in the same beat.
- State register, 58 bits: after an accepted beat it holds the last 58 scrambled bits, i.e. the wire-side stream.
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - in_ready = !seed_load & (!out_valid | out_ready).
  - Latency: 1 cycle from acceptance to out_valid.
  - out_data and out_locked are held stable while out_valid & !out_ready.
  - out_valid clears when out_ready is high and no new beat is accepted.
  - Full throughput: one beat per cycle while out_ready stays high.
- Seed load:
  - Takes priority over beat acceptance; in_ready is low in that cycle.
  - State <= seed; lock counter <= 58.
  - Does not disturb a beat already in the output register.
- Lock counter (descramble mode):
  - 6-bit, saturating at 58.
  - Adds DATA_W on each accepted beat.
  - locked = (count == 58).
  - out_locked for a beat = 1 if the counter was 58 before the beat was accepted, i.e. no tap reached reset or garbage state.
- Scramble mode: locked and out_locked are tied to 1.
- Reset, asynchronous and valid at any time including mid-beat:
  - state = 0, out_valid = 0, out_data = 0, out_locked = 0, counter = 0.
  - Therefore locked = 0 in descramble mode and 1 in scramble mode.
- No internal buffering beyond one output register; no beat is dropped or duplicated under any out_ready pattern.

Optional Feature:
- Macro SCRAMBLER_GEN_BYPASS_EN adds an input port "bypass" (1 bit).
- With the macro defined, an accepted beat with bypass = 1:
  - passes in_data unchanged to out_data;
  - does not update the state or the counter;
  - takes out_locked from the current locked value.
- With the macro undefined: no bypass port, and out_data is always processed.

Test Plan:
- Scramble, DATA_W=64, after reset, in_data=0 for 4 beats -> out_data=0 every beat; out_valid high exactly 1 cycle after each acceptance.
- Scramble, seed_load with seed=58'h3FF_FFFF_FFFF_FFFF, then in_data=64'h0 -> first out_data=64'h03FF_FF80_0000_0000.
- Loopback scramble->descramble, DATA_W=64, 1000 random beats -> out_locked=0 on beat 0, 1 from beat 1 on; descrambled data equals source from beat 1 onward.
- Loopback with DATA_W=16 and DATA_W=66 -> locked rises after ceil(58/DATA_W) beats (4 and 1); data equals source once out_locked=1.
- Random out_ready at 30% duty with continuous in_valid -> no beat lost or duplicated; out_data stable while stalled; in_ready low when out_valid & !out_ready.
- Reset asserted mid-stream, asynchronously between edges -> out_valid, out_data and locked are 0 immediately; the next 58 bits in descramble mode give out_locked=0; with bypass=1 (macro defined) the beat is echoed unchanged and state is preserved.

Source files
------------

// File: rtl/scrambler_gen.sv
// Self-synchronous 1+x^39+x^58 scrambler/descrambler with a one-beat output register.
// Optional bypass input enabled by defining SCRAMBLER_GEN_BYPASS_EN.
module scrambler_gen #(
   parameter int DATA_W = 64,
   parameter int MODE   = 0,
   parameter int SEED_W = 58
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              seed_load,
   input  logic [SEED_W-1:0] seed,
`ifdef SCRAMBLER_GEN_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_locked,
   output logic              locked
);

   localparam int         TAP_A   = SEED_W - 39;
   localparam logic [5:0] CNT_SAT = 6'(SEED_W);

   logic [SEED_W-1:0]        state;
   logic [5:0]               lock_cnt;
   logic [5:0]               cnt_next;
   logic [SEED_W+DATA_W-1:0] line;
   logic [DATA_W-1:0]        proc_data;
   logic                     accept;
   logic                     byp;

   assign in_ready = !seed_load && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign locked   = (MODE == 0) ? 1'b1 : (lock_cnt == CNT_SAT);

`ifdef SCRAMBLER_GEN_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   // line = wire-side history (oldest at bit 0) extended by this beat's wire
   // bits, so in-beat taps simply index bits already filled by the loop.
   always_comb begin
      line      = {{DATA_W{1'b0}}, state};
      proc_data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (MODE == 0) begin
            line[SEED_W+i] = in_data[i] ^ line[i+TAP_A] ^ line[i];
            proc_data[i]   = line[SEED_W+i];
         end else begin
            line[SEED_W+i] = in_data[i];
            proc_data[i]   = in_data[i] ^ line[i+TAP_A] ^ line[i];
         end
      end
   end

   always_comb begin
      cnt_next = CNT_SAT;
      if (int'(lock_cnt) + DATA_W < SEED_W)
         cnt_next = 6'(int'(lock_cnt) + DATA_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= '0;
         lock_cnt   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_locked <= 1'b0;
      end else begin
         if (seed_load) begin
            state    <= seed;
            lock_cnt <= CNT_SAT;
         end else if (accept && !byp) begin
            state    <= line[SEED_W+DATA_W-1 -: SEED_W];
            lock_cnt <= cnt_next;
         end
         if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= byp ? in_data : proc_data;
            out_locked <= locked;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scrambler_gen.sv
// Loopback bench: scrambler -> descrambler pairs at three widths against a serial bit model.
module tb_scrambler_gen;

   logic         clk;
   logic         rst;
   logic         seed_load;
   logic [57:0]  seed;
   logic         src_en;
   logic         d_or;
   logic [255:0] rnd;
   int           total;
   int           bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      total++;
      bad++;
      $display("FAIL %s got=unexpected beat want=none", nm);
   endtask

   for (genvar p = 0; p < 3; p++) begin : g
      localparam int W = (p == 0) ? 64 : (p == 1) ? 16 : 66;
      logic         s_ir, s_ov, s_ol, s_lk, d_ir, d_ov, d_ol, d_lk, pl;
      logic [W-1:0] s_od, d_od, ps, pd, ev, sc, dv;
      logic [W-1:0] q_s[$];
      logic [W-1:0] q_d[$];
      bit           q_l[$];
      bit           hs[$];
      bit           hd[$];
      bit           pss, pds, have, b;
      int           cnt;

      scrambler_gen #(.DATA_W(W), .MODE(0), .SEED_W(58)) u_s (
         .clk(clk), .reset(rst), .seed_load(seed_load), .seed(seed),
`ifdef SCRAMBLER_GEN_BYPASS_EN
         .bypass(1'b0),
`endif
         .in_valid(src_en), .in_ready(s_ir), .in_data(rnd[W-1:0]),
         .out_valid(s_ov), .out_ready(d_ir), .out_data(s_od),
         .out_locked(s_ol), .locked(s_lk));

      scrambler_gen #(.DATA_W(W), .MODE(1), .SEED_W(58)) u_d (
         .clk(clk), .reset(rst), .seed_load(seed_load), .seed(seed),
`ifdef SCRAMBLER_GEN_BYPASS_EN
         .bypass(1'b0),
`endif
         .in_valid(s_ov), .in_ready(d_ir), .in_data(s_od),
         .out_valid(d_ov), .out_ready(d_or), .out_data(d_od),
         .out_locked(d_ol), .locked(d_lk));

      // Serial model: hs/hd hold the last 58 wire bits, oldest first.
      always @(negedge clk) begin
         if (rst) begin
            hs.delete(); hd.delete(); q_s.delete(); q_d.delete(); q_l.delete();
            for (int i = 0; i < 58; i++) begin
               hs.push_back(1'b0);
               hd.push_back(1'b0);
            end
            cnt = 0; pss = 0; pds = 0;
         end else begin
            chk("s_locked", s_lk, 1'b1);
            chk("d_locked", d_lk, cnt >= 58);
            chk("s_in_ready", s_ir, !seed_load && (!s_ov || d_ir));
            chk("d_in_ready", d_ir, !seed_load && (!d_ov || d_or));
            if (pss) chk("s_hold", s_od, ps);
            if (pds) begin
               chk("d_hold", d_od, pd);
               chk("d_hold_lk", d_ol, pl);
            end
            if (d_ov && d_or) begin
               if (q_d.size() == 0) miss("d_extra");
               else begin
                  chk("d_data", d_od, q_d.pop_front());
                  chk("d_out_locked", d_ol, q_l.pop_front());
               end
            end
            have = 0;
            if (s_ov && d_ir) begin
               chk("s_out_locked", s_ol, 1'b1);
               if (q_s.size() == 0) miss("s_extra");
               else begin
                  ev = q_s.pop_front();
                  chk("s_data", s_od, ev);
                  have = 1;
               end
            end
            if (seed_load) begin
               hs.delete(); hd.delete();
               for (int i = 0; i < 58; i++) begin
                  hs.push_back(seed[i]);
                  hd.push_back(seed[i]);
               end
               cnt = 58;
            end else begin
               if (have) begin
                  for (int i = 0; i < W; i++) begin
                     dv[i] = ev[i] ^ hd[hd.size()-39] ^ hd[hd.size()-58];
                     hd.push_back(ev[i]);
                     void'(hd.pop_front());
                  end
                  q_d.push_back(dv);
                  q_l.push_back(cnt >= 58);
                  cnt += W;
               end
               if (src_en && s_ir) begin
                  for (int i = 0; i < W; i++) begin
                     b = rnd[i] ^ hs[hs.size()-39] ^ hs[hs.size()-58];
                     sc[i] = b;
                     hs.push_back(b);
                     void'(hs.pop_front());
                  end
                  q_s.push_back(sc);
               end
            end
            pss = s_ov && !d_ir; ps = s_od;
            pds = d_ov && !d_or; pd = d_od; pl = d_ol;
         end
      end
   end

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; seed_load = 1'b0; seed = '0; src_en = 1'b0; d_or = 1'b1; rnd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ov", g[0].s_ov, 1'b0);
      chk("rst_s_od", g[0].s_od, '0);
      chk("rst_d_ov", g[0].d_ov, 1'b0);
      chk("rst_d_lk", g[0].d_lk, 1'b0);
      chk("rst_s_lk", g[0].s_lk, 1'b1);
      chk("rst_d_lk66", g[2].d_lk, 1'b0);
      rst = 1'b0;

      for (int k = 1; k <= 4; k++) begin
         src_en = 1'b1;
         @(posedge clk); #1;
         chk("zero_ov", g[0].s_ov, 1'b1);
         chk("zero_od", g[0].s_od, '0);
         src_en = 1'b0;
         @(posedge clk); #1;
         chk("zero_ov_drop", g[0].s_ov, 1'b0);
         chk("zero_d_ov", g[0].d_ov, 1'b1);
         if (k == 1) begin
            chk("lock64_1", g[0].d_lk, 1'b1);
            chk("lock66_1", g[2].d_lk, 1'b1);
         end
         if (k == 3) chk("lock16_3", g[1].d_lk, 1'b0);
         if (k == 4) chk("lock16_4", g[1].d_lk, 1'b1);
      end

      @(posedge clk); #1;
      seed_load = 1'b1; seed = {58{1'b1}};
      #1 chk("seed_in_ready", g[0].s_ir, 1'b0);
      @(posedge clk); #1;
      seed_load = 1'b0; src_en = 1'b1;
      @(posedge clk); #1;
      src_en = 1'b0;
      chk("seed_od", g[0].s_od, 64'h03FF_FF80_0000_0000);
      @(posedge clk); #1;

      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 8; i++) rnd[i*32 +: 32] = $urandom();
         seed = {$urandom(), $urandom()} ;
         src_en    = ($urandom_range(0, 19) != 0);
         d_or      = ($urandom_range(0, 9) < 3);
         seed_load = (c == 1500);
         if (c == 2200) begin
            #2 rst = 1'b1;
            #1;
            chk("arst_s_ov", g[0].s_ov, 1'b0);
            chk("arst_d_ov", g[0].d_ov, 1'b0);
            chk("arst_d_od", g[0].d_od, '0);
            chk("arst_d_lk", g[0].d_lk, 1'b0);
            @(posedge clk); #1;
            rst = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end

      src_en = 1'b0; d_or = 1'b1; seed_load = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_s64", g[0].q_s.size(), 0);
      chk("drain_d64", g[0].q_d.size(), 0);
      chk("drain_s16", g[1].q_s.size(), 0);
      chk("drain_d16", g[1].q_d.size(), 0);
      chk("drain_s66", g[2].q_s.size(), 0);
      chk("drain_d66", g[2].q_d.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
